osd_ctrl: RTL and testbench

Frame-synchronous configuration and motion controller for the character OSD overlay. A host writes shadow registers through a simple valid/ready port. The block commits them to the active registers only at a vsync boundary, so the overlay never tears mid-frame. It can optionally move the overlay window in a bouncing pattern across the screen. Its outputs drive the position, enable and colour inputs of the OSD overlay stage that sits between the timing generator and the LCD output.

---
 rtl/osd_pkg.sv | 32 +++
 rtl/osd_ctrl_if.sv | 17 +
 rtl/osd_axis_bounce.sv | 46 ++++
 rtl/osd_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_osd_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osd_pkg.sv
// osd_pkg: shared definitions for the OSD controller and the overlay stage.
// Holds the position/colour widths, the host register map and the
// sequencing FSM state encoding.
package osd_pkg;

    localparam int POS_W      = 12;
    localparam int COLOR_W    = 24;
    localparam int CFG_ADDR_W = 3;
    localparam int CFG_DATA_W = 16;

    localparam logic [CFG_ADDR_W-1:0] ADDR_CTRL  = 3'd0;
    localparam logic [CFG_ADDR_W-1:0] ADDR_X     = 3'd1;
    localparam logic [CFG_ADDR_W-1:0] ADDR_Y     = 3'd2;
    localparam logic [CFG_ADDR_W-1:0] ADDR_STEP  = 3'd3;
    localparam logic [CFG_ADDR_W-1:0] ADDR_COL_L = 3'd4;
    localparam logic [CFG_ADDR_W-1:0] ADDR_COL_H = 3'd5;
    localparam logic [CFG_ADDR_W-1:0] ADDR_SPEED = 3'd6;
    localparam logic [CFG_ADDR_W-1:0] ADDR_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        MOVE   = 2'd2
    } osd_state_e;

    // Limit a requested position to the largest legal top/left coordinate.
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                   input logic [POS_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/osd_ctrl_if.sv
// osd_ctrl_if: host configuration write port.
//   cfg_wr    - write valid, held by the host until accepted
//   cfg_addr  - shadow register address
//   cfg_wdata - write data
//   cfg_ready - controller can accept a write this cycle
interface osd_ctrl_if;
    import osd_pkg::*;

    logic                  cfg_wr;
    logic [CFG_ADDR_W-1:0] cfg_addr;
    logic [CFG_DATA_W-1:0] cfg_wdata;
    logic                  cfg_ready;

    modport master (output cfg_wr, output cfg_addr, output cfg_wdata, input cfg_ready);
    modport slave  (input cfg_wr, input cfg_addr, input cfg_wdata, output cfg_ready);

endinterface

// File: rtl/osd_axis_bounce.sv
// osd_axis_bounce: one bounce step along a single axis (combinational).
//   pos, dir  - current position and direction (dir=0 increasing)
//   d         - step size; zero freezes the axis
//   max       - largest allowed position
//   pos_next, dir_next - position and direction after the step
module osd_axis_bounce
    import osd_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    input  logic [3:0]       d,
    input  logic             dir,
    input  logic [POS_W-1:0] max,
    output logic [POS_W-1:0] pos_next,
    output logic             dir_next
);

    logic [POS_W-1:0] d_ext;
    logic [POS_W:0]   sum;

    assign d_ext = {{(POS_W-4){1'b0}}, d};
    // One extra bit so pos+d can never wrap before the compare.
    assign sum   = {1'b0, pos} + {1'b0, d_ext};

    always_comb begin
        pos_next = pos;
        dir_next = dir;
        if (d != 4'd0) begin
            if (!dir) begin
                if (sum >= {1'b0, max}) begin
                    pos_next = max;
                    dir_next = 1'b1;
                end else begin
                    pos_next = sum[POS_W-1:0];
                end
            end else begin
                if (pos < d_ext) begin
                    pos_next = '0;
                    dir_next = 1'b0;
                end else begin
                    pos_next = pos - d_ext;
                end
            end
        end
    end

endmodule

// File: rtl/osd_ctrl.sv
// osd_ctrl: frame-synchronous configuration and bounce-motion controller
// for the character OSD overlay.
//   pclk, rst     - pixel clock, synchronous active-high reset
//   i_vs          - vsync; the frame boundary is its rising edge
//   cfg           - host shadow-register write port (slave side)
//   osd_en/x/y/color - active overlay settings
//   commit_pulse  - one-cycle strobe when shadow values become active
//
// state  | meaning
// IDLE   | accepting host writes, waiting for a frame boundary
// COMMIT | copying shadow registers into the active set
// MOVE   | advancing the frame divider and possibly stepping the window
module osd_ctrl
    import osd_pkg::*;
#(
    parameter int SCREEN_W = 480,
    parameter int SCREEN_H = 272,
    parameter int OSD_W    = 344,
    parameter int OSD_H    = 48,
    parameter int X0       = 77,
    parameter int Y0       = 77
)(
    input  logic               pclk,
    input  logic               rst,
    input  logic               i_vs,
    osd_ctrl_if.slave          cfg,
    output logic               osd_en,
    output logic [POS_W-1:0]   osd_x,
    output logic [POS_W-1:0]   osd_y,
    output logic [COLOR_W-1:0] osd_color,
    output logic               commit_pulse
);

    localparam logic [POS_W-1:0] XMAX   = POS_W'(SCREEN_W - OSD_W);
    localparam logic [POS_W-1:0] YMAX   = POS_W'(SCREEN_H - OSD_H);
    localparam logic [POS_W-1:0] X_RST  = POS_W'(X0);
    localparam logic [POS_W-1:0] Y_RST  = POS_W'(Y0);

    osd_state_e state, next_state;
    logic       cfg_ready;
    logic       wr_acc;

    logic vs_d, vs_rise, vs_pend;

    logic               sh_en, sh_auto, pending;
    logic [POS_W-1:0]   sh_x, sh_y;
    logic [3:0]         sh_dx, sh_dy;
    logic [COLOR_W-1:0] sh_color;
    logic [7:0]         sh_speed;

    logic               act_en, act_auto;
    logic [POS_W-1:0]   act_x, act_y;
    logic [3:0]         act_dx, act_dy;
    logic [COLOR_W-1:0] act_color;
    logic [7:0]         act_speed;
    logic               dir_x, dir_y;
    logic [7:0]         div_cnt;

    logic [POS_W-1:0]   x_next, y_next;
    logic               dir_x_next, dir_y_next;

    assign wr_acc        = cfg.cfg_wr & cfg_ready;
    assign cfg.cfg_ready = cfg_ready;

    // The edge and the pending flag are both captured at the edge itself,
    // so a commit written in the edge cycle waits for the following frame.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_d    <= 1'b0;
            vs_rise <= 1'b0;
            vs_pend <= 1'b0;
        end else begin
            vs_d    <= i_vs;
            vs_rise <= i_vs & ~vs_d;
            vs_pend <= i_vs & ~vs_d & pending;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (vs_rise) begin
                    if (vs_pend)       next_state = COMMIT;
                    else if (act_auto) next_state = MOVE;
                end
            end
            COMMIT:  next_state = sh_auto ? MOVE : IDLE;
            MOVE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sh_en    <= 1'b0;
            sh_auto  <= 1'b0;
            pending  <= 1'b0;
            sh_x     <= X_RST;
            sh_y     <= Y_RST;
            sh_dx    <= '0;
            sh_dy    <= '0;
            sh_color <= '0;
            sh_speed <= '0;
        end else begin
            if (state == COMMIT) pending <= 1'b0;
            // Placed after the clear so a simultaneous commit request survives.
            if (wr_acc) begin
                case (cfg.cfg_addr)
                    ADDR_CTRL: begin
                        sh_en   <= cfg.cfg_wdata[0];
                        sh_auto <= cfg.cfg_wdata[1];
                        if (cfg.cfg_wdata[2]) pending <= 1'b1;
                    end
                    ADDR_X:     sh_x            <= cfg.cfg_wdata[POS_W-1:0];
                    ADDR_Y:     sh_y            <= cfg.cfg_wdata[POS_W-1:0];
                    ADDR_STEP: begin
                        sh_dx <= cfg.cfg_wdata[3:0];
                        sh_dy <= cfg.cfg_wdata[7:4];
                    end
                    ADDR_COL_L: sh_color[15:0]  <= cfg.cfg_wdata;
                    ADDR_COL_H: sh_color[23:16] <= cfg.cfg_wdata[7:0];
                    ADDR_SPEED: sh_speed        <= cfg.cfg_wdata[7:0];
                    ADDR_RSVD:  ;
                    default:    ;
                endcase
            end
        end
    end

    osd_axis_bounce u_axis_x (
        .pos      (act_x),
        .d        (act_dx),
        .dir      (dir_x),
        .max      (XMAX),
        .pos_next (x_next),
        .dir_next (dir_x_next)
    );

    osd_axis_bounce u_axis_y (
        .pos      (act_y),
        .d        (act_dy),
        .dir      (dir_y),
        .max      (YMAX),
        .pos_next (y_next),
        .dir_next (dir_y_next)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            act_en       <= 1'b0;
            act_auto     <= 1'b0;
            act_x        <= X_RST;
            act_y        <= Y_RST;
            act_dx       <= '0;
            act_dy       <= '0;
            act_color    <= '0;
            act_speed    <= '0;
            dir_x        <= 1'b0;
            dir_y        <= 1'b0;
            div_cnt      <= '0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                COMMIT: begin
                    act_en       <= sh_en;
                    act_auto     <= sh_auto;
                    act_x        <= clamp_pos(sh_x, XMAX);
                    act_y        <= clamp_pos(sh_y, YMAX);
                    act_dx       <= sh_dx;
                    act_dy       <= sh_dy;
                    act_color    <= sh_color;
                    act_speed    <= sh_speed;
                    dir_x        <= 1'b0;
                    dir_y        <= 1'b0;
                    div_cnt      <= '0;
                    commit_pulse <= 1'b1;
                end
                MOVE: begin
                    if (div_cnt == act_speed) begin
                        act_x   <= x_next;
                        act_y   <= y_next;
                        dir_x   <= dir_x_next;
                        dir_y   <= dir_y_next;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign osd_en    = act_en;
    assign osd_x     = act_x;
    assign osd_y     = act_y;
    assign osd_color = act_color;

endmodule

// File: tb/tb_osd_ctrl.sv
module tb_osd_ctrl;
    import osd_pkg::*;

    typedef struct {
        logic               en;
        logic [POS_W-1:0]   x;
        logic [POS_W-1:0]   y;
        logic [COLOR_W-1:0] color;
    } snap_t;

    logic               pclk = 1'b0;
    logic               rst;
    logic               i_vs;
    logic               osd_en;
    logic [POS_W-1:0]   osd_x;
    logic [POS_W-1:0]   osd_y;
    logic [COLOR_W-1:0] osd_color;
    logic               commit_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    snap_t sb_q[$];
    int    pos_q[$];

    osd_ctrl_if cfg_if ();

    osd_ctrl dut (
        .pclk         (pclk),
        .rst          (rst),
        .i_vs         (i_vs),
        .cfg          (cfg_if),
        .osd_en       (osd_en),
        .osd_x        (osd_x),
        .osd_y        (osd_y),
        .osd_color    (osd_color),
        .commit_pulse (commit_pulse)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Starts and ends on a negedge; waits a bounded time for cfg_ready.
    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        bit ok = 0;
        cfg_if.cfg_wr    = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        for (int i = 0; i < 16; i++) begin
            if (cfg_if.cfg_ready === 1'b1) begin
                ok = 1;
                @(negedge pclk);
                break;
            end
            @(negedge pclk);
        end
        cfg_if.cfg_wr = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL write_accept: addr %0d not accepted within 16 cycles", a);
        end
    endtask

    // Frame expected to commit: pops the scoreboard at the commit strobe.
    task automatic frame_commit(input string nm);
        snap_t            e;
        int               pulses = 0;
        int               at = -1;
        logic [POS_W-1:0] x_before = osd_x;
        i_vs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                n_cmp++;
                if (cfg_if.cfg_ready !== 1'b0 || osd_x !== x_before) begin
                    n_bad++;
                    $display("FAIL %s_pre_commit: ready=%0b x=%0d, required ready=0 x=%0d",
                             nm, cfg_if.cfg_ready, osd_x, x_before);
                end
            end
            if (commit_pulse === 1'b1) begin
                pulses++;
                if (at < 0) begin
                    at = i;
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL %s_sb: commit with empty scoreboard", nm);
                    end else begin
                        e = sb_q.pop_front();
                        n_cmp++;
                        if (osd_en !== e.en) begin
                            n_bad++;
                            $display("FAIL %s_en: got %0b required %0b", nm, osd_en, e.en);
                        end
                        n_cmp++;
                        if (osd_x !== e.x) begin
                            n_bad++;
                            $display("FAIL %s_x: got %0d required %0d", nm, osd_x, e.x);
                        end
                        n_cmp++;
                        if (osd_y !== e.y) begin
                            n_bad++;
                            $display("FAIL %s_y: got %0d required %0d", nm, osd_y, e.y);
                        end
                        n_cmp++;
                        if (osd_color !== e.color) begin
                            n_bad++;
                            $display("FAIL %s_color: got %06h required %06h", nm, osd_color, e.color);
                        end
                    end
                end
            end
        end
        i_vs = 1'b0;
        repeat (3) @(negedge pclk);
        n_cmp++;
        if (at !== 2) begin
            n_bad++;
            $display("FAIL %s_latency: pulse seen at cycle %0d required 2", nm, at);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL %s_pulse_count: got %0d required 1", nm, pulses);
        end
    endtask

    // Frame expected not to commit.
    task automatic frame_plain(input string nm);
        int pulses = 0;
        i_vs = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (commit_pulse === 1'b1) pulses++;
        end
        i_vs = 1'b0;
        repeat (3) @(negedge pclk);
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL %s_no_commit: got %0d pulses required 0", nm, pulses);
        end
    endtask

    task automatic check_pos(input string nm, input logic [POS_W-1:0] got);
        int e;
        n_cmp++;
        if (pos_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: position scoreboard empty", nm);
        end else begin
            e = pos_q.pop_front();
            if (got !== POS_W'(e)) begin
                n_bad++;
                $display("FAIL %s: got %0d required %0d", nm, got, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_vs = 1'b0;
        cfg_if.cfg_wr = 1'b0;
        cfg_if.cfg_addr = '0;
        cfg_if.cfg_wdata = '0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        n_cmp++; if (osd_en !== 1'b0)     begin n_bad++; $display("FAIL reset_en: got %0b required 0", osd_en); end
        n_cmp++; if (osd_x !== 12'd77)    begin n_bad++; $display("FAIL reset_x: got %0d required 77", osd_x); end
        n_cmp++; if (osd_y !== 12'd77)    begin n_bad++; $display("FAIL reset_y: got %0d required 77", osd_y); end
        n_cmp++; if (osd_color !== 24'h0) begin n_bad++; $display("FAIL reset_color: got %06h required 0", osd_color); end
        n_cmp++; if (commit_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %0b required 0", commit_pulse); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b required 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_commit();
        cfg_write(ADDR_X, 16'd100);
        cfg_write(ADDR_Y, 16'd50);
        cfg_write(ADDR_COL_L, 16'h0000);
        cfg_write(ADDR_COL_H, 16'h00FF);
        cfg_write(ADDR_CTRL, 16'h0005);
        repeat (4) @(negedge pclk);
        n_cmp++; if (osd_x !== 12'd77) begin n_bad++; $display("FAIL commit_hold_x: got %0d required 77", osd_x); end
        n_cmp++; if (osd_en !== 1'b0)  begin n_bad++; $display("FAIL commit_hold_en: got %0b required 0", osd_en); end
        sb_q.push_back('{en: 1'b1, x: 12'd100, y: 12'd50, color: 24'hFF0000});
        frame_commit("commit");
    endtask

    task automatic test_clamp();
        cfg_write(ADDR_X, 16'd500);
        cfg_write(ADDR_CTRL, 16'h0005);
        sb_q.push_back('{en: 1'b1, x: 12'd136, y: 12'd50, color: 24'hFF0000});
        frame_commit("clamp");
    endtask

    task automatic test_auto_move();
        cfg_write(ADDR_X, 16'd130);
        cfg_write(ADDR_STEP, 16'h0004);
        cfg_write(ADDR_SPEED, 16'd0);
        cfg_write(ADDR_CTRL, 16'h0007);
        sb_q.push_back('{en: 1'b1, x: 12'd130, y: 12'd50, color: 24'hFF0000});
        pos_q.push_back(134);
        pos_q.push_back(136);
        pos_q.push_back(132);
        pos_q.push_back(128);
        frame_commit("auto");
        check_pos("auto_x0", osd_x);
        for (int f = 1; f < 4; f++) begin
            frame_plain("auto");
            check_pos($sformatf("auto_x%0d", f), osd_x);
        end
        n_cmp++; if (osd_y !== 12'd50) begin n_bad++; $display("FAIL auto_y_frozen: got %0d required 50", osd_y); end
    endtask

    task automatic test_speed();
        cfg_write(ADDR_Y, 16'd10);
        cfg_write(ADDR_STEP, 16'h0010);
        cfg_write(ADDR_SPEED, 16'd2);
        cfg_write(ADDR_CTRL, 16'h0007);
        sb_q.push_back('{en: 1'b1, x: 12'd130, y: 12'd10, color: 24'hFF0000});
        pos_q.push_back(10);
        pos_q.push_back(10);
        pos_q.push_back(11);
        pos_q.push_back(11);
        pos_q.push_back(11);
        pos_q.push_back(12);
        frame_commit("speed");
        check_pos("speed_y0", osd_y);
        for (int f = 1; f < 6; f++) begin
            frame_plain("speed");
            check_pos($sformatf("speed_y%0d", f), osd_y);
        end
        n_cmp++; if (osd_x !== 12'd130) begin n_bad++; $display("FAIL speed_x_frozen: got %0d required 130", osd_x); end
    endtask

    task automatic test_vs_edge_write();
        int pulses = 0;
        cfg_write(ADDR_X, 16'd20);
        // Commit request presented in the very cycle the vsync edge is detected.
        i_vs = 1'b1;
        cfg_if.cfg_wr = 1'b1;
        cfg_if.cfg_addr = ADDR_CTRL;
        cfg_if.cfg_wdata = 16'h0005;
        n_cmp++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL edge_write_ready: got %0b required 1", cfg_if.cfg_ready);
        end
        @(negedge pclk);
        cfg_if.cfg_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (commit_pulse === 1'b1) pulses++;
        end
        i_vs = 1'b0;
        repeat (3) @(negedge pclk);
        n_cmp++; if (pulses !== 0)       begin n_bad++; $display("FAIL edge_write_deferred: got %0d pulses required 0", pulses); end
        n_cmp++; if (osd_x !== 12'd130)  begin n_bad++; $display("FAIL edge_write_x_hold: got %0d required 130", osd_x); end
        sb_q.push_back('{en: 1'b1, x: 12'd20, y: 12'd10, color: 24'hFF0000});
        frame_commit("edge_write_next");
    endtask

    task automatic test_reset_mid();
        cfg_write(ADDR_X, 16'd60);
        cfg_write(ADDR_CTRL, 16'h0005);
        i_vs = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        n_cmp++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_in_commit: ready=%0b required 0", cfg_if.cfg_ready);
        end
        rst = 1'b1;
        @(negedge pclk);
        n_cmp++; if (osd_en !== 1'b0)       begin n_bad++; $display("FAIL rstmid_en: got %0b required 0", osd_en); end
        n_cmp++; if (osd_x !== 12'd77)      begin n_bad++; $display("FAIL rstmid_x: got %0d required 77", osd_x); end
        n_cmp++; if (osd_y !== 12'd77)      begin n_bad++; $display("FAIL rstmid_y: got %0d required 77", osd_y); end
        n_cmp++; if (osd_color !== 24'h0)   begin n_bad++; $display("FAIL rstmid_color: got %06h required 0", osd_color); end
        n_cmp++; if (commit_pulse !== 1'b0) begin n_bad++; $display("FAIL rstmid_pulse: got %0b required 0", commit_pulse); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %0b required 1", cfg_if.cfg_ready); end
        rst = 1'b0;
        i_vs = 1'b0;
        repeat (3) @(negedge pclk);
        frame_plain("rstmid_after");
        n_cmp++; if (osd_x !== 12'd77) begin n_bad++; $display("FAIL rstmid_after_x: got %0d required 77", osd_x); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_clamp();
        test_auto_move();
        test_speed();
        test_vs_edge_write();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0 || pos_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d snapshots and %0d positions left, required 0",
                     sb_q.size(), pos_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
